// File: rtl/cacheline_burst_if.sv
// Bundle of cache-side line request signals and memory-side burst signals.
// Cache side: request held until the one-cycle line_resp_o; memory side: read/write and address held for the burst, one beat per cycle with pmem_resp_i=1.
interface cacheline_burst_if #(
  parameter int CACHE_LINE_WIDTH = 256,
  parameter int BURST_LEN        = 4,
  parameter int ADDR_WIDTH       = 32
);
  localparam int BURST_WIDTH = CACHE_LINE_WIDTH / BURST_LEN;

  logic                        line_read_i;
  logic                        line_write_i;
  logic [ADDR_WIDTH-1:0]       line_addr_i;
  logic [CACHE_LINE_WIDTH-1:0] line_wdata_i;
  logic [CACHE_LINE_WIDTH-1:0] line_rdata_o;
  logic                        line_resp_o;
  logic                        line_err_o;
  logic                        pmem_read_o;
  logic                        pmem_write_o;
  logic [ADDR_WIDTH-1:0]       pmem_addr_o;
  logic [BURST_WIDTH-1:0]      pmem_wdata_o;
  logic [BURST_WIDTH-1:0]      pmem_rdata_i;
  logic                        pmem_resp_i;
  logic                        pmem_error_i;

  modport master (
    input  line_read_i, line_write_i, line_addr_i, line_wdata_i,
    input  pmem_rdata_i, pmem_resp_i, pmem_error_i,
    output line_rdata_o, line_resp_o, line_err_o,
    output pmem_read_o, pmem_write_o, pmem_addr_o, pmem_wdata_o
  );

  modport slave (
    output line_read_i, line_write_i, line_addr_i, line_wdata_i,
    output pmem_rdata_i, pmem_resp_i, pmem_error_i,
    input  line_rdata_o, line_resp_o, line_err_o,
    input  pmem_read_o, pmem_write_o, pmem_addr_o, pmem_wdata_o
  );
endinterface

// File: rtl/cacheline_burst_adaptor.sv
// Converts single-cycle full-line cache requests into BURST_LEN-beat memory bursts,
// lowest slice first, with stall tolerance and memory-error abort.
module cacheline_burst_adaptor #(
  parameter int CACHE_LINE_WIDTH = 256,
  parameter int BURST_LEN        = 4,
  parameter int ADDR_WIDTH       = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cacheline_burst_if.master     bus,
  output logic [1:0]            dbg_state
);
  localparam int BURST_WIDTH = CACHE_LINE_WIDTH / BURST_LEN;
  localparam int OFFSET      = $clog2(CACHE_LINE_WIDTH / 8);
  localparam int CNT_W       = $clog2(BURST_LEN) + 1;
  localparam int IDX_W       = $clog2(BURST_LEN);
  localparam logic [CNT_W-1:0]      LAST_BEAT = CNT_W'(BURST_LEN - 1);
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK  = ADDR_WIDTH'((64'd1 << OFFSET) - 64'd1);

  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2, DONE = 2'd3} state_e;

  state_e                      state, state_n;
  logic [CNT_W-1:0]            cnt;
  logic [IDX_W-1:0]            beat_idx;
  logic [ADDR_WIDTH-1:0]       addr_q;
  logic [CACHE_LINE_WIDTH-1:0] wline_q;
  logic [CACHE_LINE_WIDTH-1:0] rline_q;
  logic                        err_q;
  logic                        accept_rd, accept_wr;

  assign accept_rd = bus.line_read_i  & ~bus.line_write_i;
  assign accept_wr = bus.line_write_i & ~bus.line_read_i;
  assign beat_idx  = cnt[IDX_W-1:0];
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (accept_rd)      state_n = RD;
        else if (accept_wr) state_n = WR;
      end
      RD, WR: begin
        if (bus.pmem_error_i)                          state_n = DONE;
        else if (bus.pmem_resp_i && cnt == LAST_BEAT)  state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Datapath: address/line latches, beat counter, read assembly, abort flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      addr_q  <= '0;
      wline_q <= '0;
      rline_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept_rd || accept_wr) begin
            addr_q <= bus.line_addr_i & ~OFF_MASK;
            err_q  <= 1'b0;
          end
          if (accept_wr) wline_q <= bus.line_wdata_i;
        end
        RD, WR: begin
          if (bus.pmem_error_i) begin
            err_q <= 1'b1;
          end else if (bus.pmem_resp_i) begin
            cnt <= cnt + 1'b1;
            if (state == RD) rline_q[beat_idx*BURST_WIDTH +: BURST_WIDTH] <= bus.pmem_rdata_i;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

  always_comb begin
    bus.pmem_read_o  = (state == RD);
    bus.pmem_write_o = (state == WR);
    bus.line_resp_o  = (state == DONE);
    bus.line_err_o   = ((state == DONE) && err_q) ||
                       ((state == IDLE) && bus.line_read_i && bus.line_write_i);
  end

  assign bus.pmem_addr_o  = addr_q;
  assign bus.pmem_wdata_o = wline_q[beat_idx*BURST_WIDTH +: BURST_WIDTH];
  assign bus.line_rdata_o = rline_q;
endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// Bench for cacheline_burst_adaptor: acts as cache and as a line-addressed memory
// with random stalls; expected values come from a line-level memory model.
module tb_cacheline_burst_adaptor;
  localparam int LW  = 256;
  localparam int BL  = 4;
  localparam int AW  = 32;
  localparam int BW  = LW / BL;
  localparam logic [AW-1:0] LINE_MASK = 32'h0000_001F;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;
  int         vectors;
  int         miscompares;
  int         gap_pat[$];
  logic [LW-1:0] mem [logic [AW-1:0]];

  cacheline_burst_if #(.CACHE_LINE_WIDTH(LW), .BURST_LEN(BL), .ADDR_WIDTH(AW)) bif ();

  cacheline_burst_adaptor #(.CACHE_LINE_WIDTH(LW), .BURST_LEN(BL), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bif.master), .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] l;
    for (int k = 0; k < LW / 32; k++) l[k*32 +: 32] = $urandom();
    return l;
  endfunction

  task automatic idle_inputs();
    bif.line_read_i  = 1'b0;
    bif.line_write_i = 1'b0;
    bif.line_addr_i  = '0;
    bif.line_wdata_i = '0;
    bif.pmem_rdata_i = '0;
    bif.pmem_resp_i  = 1'b0;
    bif.pmem_error_i = 1'b0;
  endtask

  // One full cache transaction, with the bench acting as memory.
  task automatic run_xfer(input bit wr, input logic [AW-1:0] addr, input logic [LW-1:0] wline,
                          input int stall_pct, input int err_beat, output logic [LW-1:0] rline);
    logic [AW-1:0] aligned;
    logic [LW-1:0] exp_line, recv;
    bit exp_err, done, fire;
    int beat, cycles;
    aligned = addr & ~LINE_MASK;
    exp_err = (err_beat >= 0);
    if (!wr && !mem.exists(aligned)) mem[aligned] = rand_line();
    exp_line = wr ? wline : mem[aligned];
    recv = '0;
    @(negedge clk);
    bif.line_read_i  = !wr;
    bif.line_write_i = wr;
    bif.line_addr_i  = addr;
    bif.line_wdata_i = wline;
    @(posedge clk);
    beat = 0; done = 1'b0; cycles = 0;
    while (!done && cycles < 200) begin
      @(negedge clk);
      cycles++;
      vectors++;
      if (bif.pmem_read_o !== !wr || bif.pmem_write_o !== wr || bif.pmem_addr_o !== aligned ||
          bif.line_resp_o !== 1'b0) begin
        miscompares++;
        $display("FAIL burst_hold: rd=%b wr=%b addr=%h resp=%b, want rd=%b wr=%b addr=%h resp=0",
                 bif.pmem_read_o, bif.pmem_write_o, bif.pmem_addr_o, bif.line_resp_o, !wr, wr, aligned);
      end
      if (beat == err_beat) begin
        bif.pmem_error_i = 1'b1;
        done = 1'b1;
      end else begin
        if (gap_pat.size() > 0) fire = (gap_pat.pop_front() != 0);
        else fire = ($urandom_range(99) >= stall_pct);
        if (fire) begin
          bif.pmem_resp_i = 1'b1;
          if (wr) begin
            vectors++;
            if (bif.pmem_wdata_o !== exp_line[beat*BW +: BW]) begin
              miscompares++;
              $display("FAIL wdata_beat%0d: got %h, want %h", beat, bif.pmem_wdata_o, exp_line[beat*BW +: BW]);
            end
            recv[beat*BW +: BW] = bif.pmem_wdata_o;
          end else begin
            bif.pmem_rdata_i = exp_line[beat*BW +: BW];
          end
          beat++;
          if (beat == BL) done = 1'b1;
        end else begin
          bif.pmem_rdata_i = rand_line()[BW-1:0];
        end
      end
      @(posedge clk);
      #1;
      bif.pmem_resp_i  = 1'b0;
      bif.pmem_error_i = 1'b0;
    end
    if (!done) begin
      miscompares++;
      $display("FAIL xfer_timeout: beats=%0d, want %0d within 200 cycles", beat, BL);
    end
    @(negedge clk);
    vectors++;
    if (bif.pmem_read_o !== 1'b0 || bif.pmem_write_o !== 1'b0 || bif.line_resp_o !== 1'b1 ||
        bif.line_err_o !== exp_err) begin
      miscompares++;
      $display("FAIL completion: rd=%b wr=%b resp=%b err=%b, want rd=0 wr=0 resp=1 err=%b",
               bif.pmem_read_o, bif.pmem_write_o, bif.line_resp_o, bif.line_err_o, exp_err);
    end
    if (!exp_err && !wr) begin
      vectors++;
      if (bif.line_rdata_o !== exp_line) begin
        miscompares++;
        $display("FAIL read_line: got %h, want %h", bif.line_rdata_o, exp_line);
      end
    end
    if (!exp_err && wr) begin
      vectors++;
      if (recv !== wline) begin
        miscompares++;
        $display("FAIL mem_line: got %h, want %h", recv, wline);
      end
      mem[aligned] = wline;
    end
    rline = bif.line_rdata_o;
    bif.line_read_i  = 1'b0;
    bif.line_write_i = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      vectors++;
      if (bif.line_resp_o !== 1'b0 || bif.pmem_read_o !== 1'b0 || bif.pmem_write_o !== 1'b0) begin
        miscompares++;
        $display("FAIL after_done%0d: resp=%b rd=%b wr=%b, want all 0", c, bif.line_resp_o,
                 bif.pmem_read_o, bif.pmem_write_o);
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    vectors++;
    if (bif.line_rdata_o !== '0 || bif.line_resp_o !== 1'b0 || bif.line_err_o !== 1'b0 ||
        bif.pmem_read_o !== 1'b0 || bif.pmem_write_o !== 1'b0 || bif.pmem_addr_o !== '0 ||
        bif.pmem_wdata_o !== '0) begin
      miscompares++;
      $display("FAIL %s: rdata=%h resp=%b err=%b rd=%b wr=%b addr=%h wdata=%h, want all 0", tag,
               bif.line_rdata_o, bif.line_resp_o, bif.line_err_o, bif.pmem_read_o, bif.pmem_write_o,
               bif.pmem_addr_o, bif.pmem_wdata_o);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset_state");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_read();
    logic [LW-1:0] r;
    mem[32'h0000_1220] = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
    run_xfer(1'b0, 32'h0000_1234, '0, 0, -1, r);
    vectors++;
    if (r !== {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}}) begin
      miscompares++;
      $display("FAIL read_vector: got %h", r);
    end
  endtask

  task automatic test_write();
    logic [LW-1:0] r, l;
    l = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
    run_xfer(1'b1, 32'h0000_0040, l, 0, -1, r);
  endtask

  task automatic test_resp_gaps();
    logic [LW-1:0] r;
    gap_pat = '{1, 0, 0, 1, 1, 0, 1};
    run_xfer(1'b0, 32'h0000_05C7, '0, 0, -1, r);
    gap_pat = '{0, 0, 1, 0, 1, 1, 0, 0, 1};
    run_xfer(1'b1, 32'h0000_0600, rand_line(), 0, -1, r);
  endtask

  task automatic test_back_to_back();
    logic [LW-1:0] r, l;
    l = rand_line();
    run_xfer(1'b1, 32'h0000_0080, l, 30, -1, r);
    run_xfer(1'b0, 32'h0000_0080, '0, 30, -1, r);
    vectors++;
    if (r !== l) begin
      miscompares++;
      $display("FAIL back_to_back: got %h, want %h", r, l);
    end
  endtask

  task automatic test_illegal();
    logic [LW-1:0] r;
    @(negedge clk);
    bif.line_read_i  = 1'b1;
    bif.line_write_i = 1'b1;
    bif.line_addr_i  = 32'h0000_0700;
    #1;
    vectors++;
    if (bif.line_err_o !== 1'b1 || bif.pmem_read_o !== 1'b0 || bif.pmem_write_o !== 1'b0) begin
      miscompares++;
      $display("FAIL illegal_req: err=%b rd=%b wr=%b, want err=1 rd=0 wr=0", bif.line_err_o,
               bif.pmem_read_o, bif.pmem_write_o);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    vectors++;
    if (bif.line_err_o !== 1'b0 || bif.pmem_read_o !== 1'b0 || bif.pmem_write_o !== 1'b0 ||
        bif.line_resp_o !== 1'b0) begin
      miscompares++;
      $display("FAIL illegal_after: err=%b rd=%b wr=%b resp=%b, want all 0", bif.line_err_o,
               bif.pmem_read_o, bif.pmem_write_o, bif.line_resp_o);
    end
    run_xfer(1'b0, 32'h0000_0300, '0, 20, 2, r);
    run_xfer(1'b1, 32'h0000_0320, rand_line(), 20, 1, r);
  endtask

  task automatic test_reset_mid_burst();
    logic [LW-1:0] r;
    @(negedge clk);
    bif.line_write_i = 1'b1;
    bif.line_addr_i  = 32'h0000_0200;
    bif.line_wdata_i = rand_line();
    @(posedge clk);
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      bif.pmem_resp_i = 1'b1;
      @(posedge clk);
      #1 bif.pmem_resp_i = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("reset_mid_burst");
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    mem[32'h0000_0100] = rand_line();
    run_xfer(1'b0, 32'h0000_0100, '0, 0, -1, r);
  endtask

  task automatic test_random();
    logic [LW-1:0] r;
    logic [AW-1:0] a;
    for (int n = 0; n < 16; n++) begin
      a = {$urandom_range(15), 5'd0} | AW'($urandom_range(31));
      if ($urandom_range(1) == 1) run_xfer(1'b1, a, rand_line(), $urandom_range(60), -1, r);
      else                        run_xfer(1'b0, a, '0, $urandom_range(60), -1, r);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_read();
    test_write();
    test_resp_gaps();
    test_back_to_back();
    test_illegal();
    test_reset_mid_burst();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
